// File: rtl/bus_pkg.sv
// bus_pkg: constants shared by the acquire (fsm_ocupar_bus) and release
// FSMs of the shared filter bus.
//   - E_LIBRE..E_GUARDA : 2-bit state encoding of the acquire FSM
//   - ID_REQ_1/ID_REQ_2 : requester identifiers held in dueno/ultimo
//   - CNT_W_DEF, TIMEOUT_CICLOS_DEF : default parameter values
//   - otro_id()         : the other requester, used for round-robin ties
package bus_pkg;

  localparam logic [1:0] E_LIBRE    = 2'd0;
  localparam logic [1:0] E_CONCEDER = 2'd1;
  localparam logic [1:0] E_OCUPADO  = 2'd2;
  localparam logic [1:0] E_GUARDA   = 2'd3;

  localparam logic [1:0] ID_REQ_1 = 2'd1;
  localparam logic [1:0] ID_REQ_2 = 2'd2;

  localparam int CNT_W_DEF          = 8;
  localparam int TIMEOUT_CICLOS_DEF = 1024;

  function automatic logic [1:0] otro_id(input logic [1:0] id);
    return (id == ID_REQ_1) ? ID_REQ_2 : ID_REQ_1;
  endfunction

endpackage

// File: rtl/temporizador_bus.sv
// temporizador_bus: watchdog for the time the bus stays held.
// Down-counter loaded with LIMITE-1 on borrar, decremented while habilitar
// is high, saturating at zero; expirado flags the terminal count.
// With the counter loaded one cycle before the first enabled cycle,
// expirado rises on the LIMITE-th enabled cycle.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   borrar    reload the counter
//   habilitar count one cycle
//   expirado  terminal count reached
module temporizador_bus #(
  parameter int LIMITE = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic borrar,
  input  logic habilitar,
  output logic expirado
);

  localparam int          W     = (LIMITE > 2) ? $clog2(LIMITE) : 1;
  localparam logic [W-1:0] CARGA = W'(LIMITE - 1);

  logic [W-1:0] cuenta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta <= CARGA;
    end else if (borrar) begin
      cuenta <= CARGA;
    end else if (habilitar && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  assign expirado = (cuenta == '0);

endmodule

// File: rtl/fsm_ocupar_bus.sv
// fsm_ocupar_bus: acquire side of the shared filter bus.
// Arbitrates two requesters (round-robin on ties), holds the grant until
// the release FSM pulses liberar_bus, then spends one guard cycle before
// arbitrating again. Counts completed transfers.
//
//   state      | meaning
//   E_LIBRE    | bus free, sampling requests
//   E_CONCEDER | grant + one-cycle start strobe to dueno
//   E_OCUPADO  | grant held, waiting for liberar_bus
//   E_GUARDA   | guard cycle: update ultimo, count transfer
//
// Optional macro FSM_OCUPAR_BUS_TIMEOUT_EN adds a watchdog that forces the
// release after TIMEOUT_CICLOS cycles in E_OCUPADO and sets a sticky
// error_timeout; without it error_timeout is tied to 0.
// Ports:
//   clk, reset                 clock and async active-low reset
//   solicitar_1/2              level requests
//   liberar_bus                one-cycle release pulse
//   conceder_1/2               level grants
//   iniciar_1/2                one-cycle start strobes
//   bus_ocupado                any grant held
//   contador_transferencias    completed transfers, wraps
//   error_timeout              sticky watchdog flag
module fsm_ocupar_bus
  import bus_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             solicitar_1,
  input  logic             solicitar_2,
  input  logic             liberar_bus,
  output logic             conceder_1,
  output logic             conceder_2,
  output logic             iniciar_1,
  output logic             iniciar_2,
  output logic             bus_ocupado,
  output logic [CNT_W-1:0] contador_transferencias,
  output logic             error_timeout
);

  logic [1:0]       e_actual, e_siguiente;
  logic [1:0]       dueno, dueno_sig;
  logic [1:0]       ultimo;
  logic [CNT_W-1:0] contador;
  logic             timeout_forzado;

`ifdef FSM_OCUPAR_BUS_TIMEOUT_EN
  logic expirado;
  logic error_q;

  // Loading in E_CONCEDER is the same as clearing on entry to E_OCUPADO,
  // since E_CONCEDER is the only way in.
  temporizador_bus #(
    .LIMITE(TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .borrar   (e_actual == E_CONCEDER),
    .habilitar(e_actual == E_OCUPADO),
    .expirado (expirado)
  );

  // A release arriving on the same cycle as the timeout takes priority.
  assign timeout_forzado = (e_actual == E_OCUPADO) && expirado && !liberar_bus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (timeout_forzado) begin
      error_q <= 1'b1;
    end
  end

  assign error_timeout = error_q;
`else
  logic timeout_unused;
  assign timeout_unused  = ^TIMEOUT_CICLOS;
  assign timeout_forzado = 1'b0;
  assign error_timeout   = 1'b0;
`endif

  always_comb begin
    e_siguiente = e_actual;
    dueno_sig   = dueno;
    case (e_actual)
      E_LIBRE: begin
        if (solicitar_1 && solicitar_2) begin
          dueno_sig   = otro_id(ultimo);
          e_siguiente = E_CONCEDER;
        end else if (solicitar_1) begin
          dueno_sig   = ID_REQ_1;
          e_siguiente = E_CONCEDER;
        end else if (solicitar_2) begin
          dueno_sig   = ID_REQ_2;
          e_siguiente = E_CONCEDER;
        end
      end
      E_CONCEDER: e_siguiente = E_OCUPADO;
      E_OCUPADO: begin
        if (liberar_bus || timeout_forzado) begin
          e_siguiente = E_GUARDA;
        end
      end
      E_GUARDA: e_siguiente = E_LIBRE;
      default:  e_siguiente = E_LIBRE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_actual <= E_LIBRE;
      dueno    <= ID_REQ_1;
      ultimo   <= ID_REQ_2;
      contador <= '0;
    end else begin
      e_actual <= e_siguiente;
      dueno    <= dueno_sig;
      if (e_actual == E_GUARDA) begin
        ultimo   <= dueno;
        contador <= contador + 1'b1;
      end
    end
  end

  assign conceder_1 = ((e_actual == E_CONCEDER) || (e_actual == E_OCUPADO)) &&
                      (dueno == ID_REQ_1);
  assign conceder_2 = ((e_actual == E_CONCEDER) || (e_actual == E_OCUPADO)) &&
                      (dueno == ID_REQ_2);
  assign iniciar_1  = (e_actual == E_CONCEDER) && (dueno == ID_REQ_1);
  assign iniciar_2  = (e_actual == E_CONCEDER) && (dueno == ID_REQ_2);
  assign bus_ocupado = conceder_1 | conceder_2;
  assign contador_transferencias = contador;

endmodule

// File: tb/tb_fsm_ocupar_bus.sv
// Bench for fsm_ocupar_bus: two instances share stimulus, the default
// CNT_W=8 one and a CNT_W=2 one for the wrap-around case. Expected owners
// and transfer counts are queued as stimulus is driven and popped by a
// monitor when the DUT strobes iniciar_x or completes a release.
module tb_fsm_ocupar_bus;

  logic clk = 1'b0;
  logic reset;
  logic solicitar_1, solicitar_2, liberar_bus;

  logic       conceder_1, conceder_2, iniciar_1, iniciar_2, bus_ocupado, error_timeout;
  logic [7:0] contador;
  logic       b_conceder_1, b_conceder_2, b_iniciar_1, b_iniciar_2, b_bus_ocupado, b_error;
  logic [1:0] b_contador;

  fsm_ocupar_bus #(.CNT_W(8), .TIMEOUT_CICLOS(16)) dut (
    .clk(clk), .reset(reset),
    .solicitar_1(solicitar_1), .solicitar_2(solicitar_2), .liberar_bus(liberar_bus),
    .conceder_1(conceder_1), .conceder_2(conceder_2),
    .iniciar_1(iniciar_1), .iniciar_2(iniciar_2),
    .bus_ocupado(bus_ocupado), .contador_transferencias(contador),
    .error_timeout(error_timeout)
  );

  fsm_ocupar_bus #(.CNT_W(2), .TIMEOUT_CICLOS(16)) dut2 (
    .clk(clk), .reset(reset),
    .solicitar_1(solicitar_1), .solicitar_2(solicitar_2), .liberar_bus(liberar_bus),
    .conceder_1(b_conceder_1), .conceder_2(b_conceder_2),
    .iniciar_1(b_iniciar_1), .iniciar_2(b_iniciar_2),
    .bus_ocupado(b_bus_ocupado), .contador_transferencias(b_contador),
    .error_timeout(b_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic comprobar(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  int q_dueno[$];
  int q_cnt[$];
  int cnt_model;
  int mon_e;
  bit prev_busy;
  bit pend;

  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      pend      = 1'b0;
    end else begin
      if (iniciar_1 || iniciar_2) begin
        if (q_dueno.size() == 0) begin
          comprobar("iniciar_unexpected", 1, 0);
        end else begin
          mon_e = q_dueno.pop_front();
          comprobar("owner", iniciar_1 ? 1 : 2, mon_e);
        end
        comprobar("iniciar_vs_grant", {iniciar_1, iniciar_2}, {conceder_1, conceder_2});
      end
      if (bus_ocupado) begin
        comprobar("grant_excl", conceder_1 && conceder_2, 0);
        comprobar("dut2_grant", {b_conceder_1, b_conceder_2}, {conceder_1, conceder_2});
      end
      comprobar("busy_decode", bus_ocupado, conceder_1 | conceder_2);
      if (pend) begin
        if (q_cnt.size() == 0) begin
          comprobar("release_unexpected", 1, 0);
        end else begin
          mon_e = q_cnt.pop_front();
          comprobar("counter", contador, mon_e % 256);
          comprobar("counter_w2", b_contador, mon_e % 4);
        end
        pend = 1'b0;
      end
      if (prev_busy && !bus_ocupado) pend = 1'b1;
      prev_busy = bus_ocupado;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    solicitar_1 = 0; solicitar_2 = 0; liberar_bus = 0;
    reset = 0;
    q_dueno.delete();
    q_cnt.delete();
    cnt_model = 0;
    tick;
    comprobar("reset_outs", {conceder_1, conceder_2, iniciar_1, iniciar_2, bus_ocupado, error_timeout}, 0);
    comprobar("reset_cnt", contador, 0);
    @(negedge clk);
    reset = 1;
    tick;
  endtask

  // Waits for the start strobe, checks its latency and width, holds the
  // bus, then pulses liberar_bus and checks the grant drops.
  task automatic transferencia(input int owner, input int exp_lat, input int hold);
    int n;
    q_dueno.push_back(owner);
    n = 0;
    while (!(iniciar_1 || iniciar_2) && n < 8) begin
      tick;
      n++;
    end
    comprobar("latency", n, exp_lat);
    tick;
    comprobar("iniciar_pulse", {iniciar_1, iniciar_2}, 0);
    comprobar("grant_held", (owner == 1) ? conceder_1 : conceder_2, 1);
    repeat (hold) tick;
    liberar_bus = 1;
    cnt_model++;
    q_cnt.push_back(cnt_model);
    tick;
    liberar_bus = 0;
    comprobar("grant_drop", bus_ocupado, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 0;
    solicitar_1 = 0; solicitar_2 = 0; liberar_bus = 0;
    #3;
    do_reset;

    // Single requester
    solicitar_1 = 1;
    transferencia(1, 1, 3);
    solicitar_1 = 0;
    tick; tick;
    comprobar("cnt_single", contador, 1);

    // Both held: alternation 1,2,1,2 with 3-cycle turnaround
    do_reset;
    solicitar_1 = 1; solicitar_2 = 1;
    transferencia(1, 1, 2);
    transferencia(2, 2, 2);
    transferencia(1, 2, 0);
    transferencia(2, 2, 4);
    solicitar_1 = 0; solicitar_2 = 0;
    tick; tick;
    comprobar("cnt_four", contador, 4);
    comprobar("cnt_four_w2", b_contador, 0);
    solicitar_2 = 1;
    transferencia(2, 1, 1);
    solicitar_2 = 0;
    tick; tick;
    comprobar("cnt_five_w2", b_contador, 1);

    // liberar_bus in E_LIBRE and E_CONCEDER is ignored
    liberar_bus = 1;
    tick;
    liberar_bus = 0;
    comprobar("lib_in_libre", bus_ocupado, 0);
    solicitar_1 = 1;
    q_dueno.push_back(1);
    tick;
    comprobar("conceder_entry", iniciar_1, 1);
    liberar_bus = 1;
    tick;
    liberar_bus = 0;
    solicitar_1 = 0;
    comprobar("lib_in_conceder", conceder_1, 1);
    tick; tick;
    comprobar("held_after_ignored", conceder_1, 1);
    liberar_bus = 1;
    cnt_model++;
    q_cnt.push_back(cnt_model);
    tick;
    liberar_bus = 0;
    comprobar("release_ocupado", bus_ocupado, 0);
    tick; tick;
    comprobar("cnt_six", contador, 6);

    // Owner drops request mid-grant, then async reset mid-grant
    solicitar_1 = 1;
    q_dueno.push_back(1);
    tick;
    comprobar("grant1", conceder_1, 1);
    solicitar_1 = 0; solicitar_2 = 1;
    repeat (5) tick;
    comprobar("owner_drop_held", {conceder_1, conceder_2}, 2'b10);
    #3;
    reset = 0;
    #1;
    comprobar("async_reset_outs", {conceder_1, conceder_2, iniciar_1, iniciar_2, bus_ocupado, error_timeout}, 0);
    comprobar("async_reset_cnt", contador, 0);
    q_dueno.delete();
    q_cnt.delete();
    cnt_model = 0;
    solicitar_1 = 1;
    @(negedge clk);
    reset = 1;
    transferencia(1, 1, 2);
    solicitar_1 = 0; solicitar_2 = 0;
    tick; tick;

    // Watchdog
    solicitar_1 = 1;
    q_dueno.push_back(1);
    tick;
    comprobar("wd_grant", iniciar_1, 1);
    solicitar_1 = 0;
`ifdef FSM_OCUPAR_BUS_TIMEOUT_EN
    cnt_model++;
    q_cnt.push_back(cnt_model);
    n = 0;
    while (conceder_1 && n < 40) begin
      tick;
      n++;
    end
    comprobar("ocupado_cycles", n - 1, 16);
    comprobar("error_set", error_timeout, 1);
    tick; tick;
    solicitar_2 = 1;
    transferencia(2, 1, 1);
    solicitar_2 = 0;
    tick; tick;
    comprobar("error_sticky", error_timeout, 1);
`else
    repeat (40) tick;
    comprobar("held_no_wd", conceder_1, 1);
    comprobar("no_error", error_timeout, 0);
    liberar_bus = 1;
    cnt_model++;
    q_cnt.push_back(cnt_model);
    tick;
    liberar_bus = 0;
    comprobar("release_late", bus_ocupado, 0);
    tick; tick;
    comprobar("no_error_after", error_timeout, 0);
`endif
    comprobar("queue_empty", q_dueno.size() + q_cnt.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
